// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer: condition codes, IR field positions, FSM states.
package branch_pkg;

  localparam logic [1:0] COND_EQZ = 2'b00;
  localparam logic [1:0] COND_NEZ = 2'b01;
  localparam logic [1:0] COND_GEZ = 2'b10;
  localparam logic [1:0] COND_LTZ = 2'b11;

  localparam int RA_MSB   = 26;
  localparam int RA_LSB   = 23;
  localparam int COND_MSB = 20;
  localparam int COND_LSB = 19;
  localparam int C_MSB    = 18;
  localparam int C_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_STROBE,
    ST_EVAL,
    ST_DONE
  } state_t;

  // Flag the CON flip-flop should latch for a given condition and bus value.
  function automatic logic cond_flag(input logic [1:0] cond, input logic [31:0] value);
    logic result;
    result = 1'b0;
    case (cond)
      COND_EQZ: result = (value == 32'h0);
      COND_NEZ: result = (value != 32'h0);
      COND_GEZ: result = ~value[31];
      COND_LTZ: result = value[31];
      default:  result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Control-unit <-> branch sequencer signal bundle; out_mismatch exists only with BRANCH_CHECK_EN.
interface branch_sequencer_if;

  logic        in_start;
  logic [31:0] in_ir;
  logic        in_pc_inc;
  logic        in_branch;
  logic [31:0] in_bus;
  logic [3:0]  out_ra_sel;
  logic        out_ra_out;
  logic [1:0]  out_condition;
  logic        out_con_in;
  logic [31:0] out_pc;
  logic        out_busy;
  logic        out_done;
  logic        out_taken;
`ifdef BRANCH_CHECK_EN
  logic        out_mismatch;
`endif

  modport master (
    output in_start, in_ir, in_pc_inc, in_branch, in_bus,
    input  out_ra_sel, out_ra_out, out_condition, out_con_in,
    input  out_pc, out_busy, out_done, out_taken
`ifdef BRANCH_CHECK_EN
    , input out_mismatch
`endif
  );

  modport slave (
    input  in_start, in_ir, in_pc_inc, in_branch, in_bus,
    output out_ra_sel, out_ra_out, out_condition, out_con_in,
    output out_pc, out_busy, out_done, out_taken
`ifdef BRANCH_CHECK_EN
    , output out_mismatch
`endif
  );

endinterface

// File: rtl/branch_sequencer_adder.sv
// branch_target_adder: pc + sign-extended branch displacement, wrapping modulo 2^32.
module branch_target_adder #(
  parameter int OFFSET_W = 19
) (
  input  logic [31:0]         i_pc,
  input  logic [OFFSET_W-1:0] i_offset,
  output logic [31:0]         o_target
);

  logic [31:0] w_offset_ext;

  assign w_offset_ext = {{(32-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};
  assign o_target     = i_pc + w_offset_ext;

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: drives Ra, strobes CON, samples the branch flag and updates the PC.
// Define BRANCH_CHECK_EN to cross-check in_branch against the bus and report out_mismatch.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OFFSET_W = 19
) (
  input logic               clk,
  input logic               clr,
  branch_sequencer_if.slave seq
);

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;

  logic [3:0]            r_ra;
  logic [1:0]            r_cond;
  logic [OFFSET_W-1:0]   r_c;
  logic [31:0]           r_pc;
  logic [31:0]           w_target;

  logic [3:0]            r_ra_sel;
  logic                  r_ra_out;
  logic [1:0]            r_condition;
  logic                  r_con_in;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_taken;

  logic [3:0]            w_ra_sel;
  logic                  w_ra_out;
  logic [1:0]            w_condition;
  logic                  w_con_in;
  logic                  w_busy;
  logic                  w_done;

  assign w_accept = (r_state == ST_IDLE) && seq.in_start;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (seq.in_start) w_next = ST_DRIVE;
      ST_DRIVE:  w_next = ST_STROBE;
      ST_STROBE: w_next = ST_EVAL;
      ST_EVAL:   w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with r_state.
  always_comb begin
    w_ra_out    = (w_next == ST_DRIVE) || (w_next == ST_STROBE);
    w_con_in    = (w_next == ST_STROBE);
    w_busy      = (w_next != ST_IDLE);
    w_done      = (w_next == ST_DONE);
    w_ra_sel    = 4'h0;
    w_condition = 2'b00;
    if (w_busy) begin
      w_ra_sel    = w_accept ? seq.in_ir[RA_MSB:RA_LSB]     : r_ra;
      w_condition = w_accept ? seq.in_ir[COND_MSB:COND_LSB] : r_cond;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ra_sel    <= 4'h0;
      r_ra_out    <= 1'b0;
      r_condition <= 2'b00;
      r_con_in    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ra_sel    <= w_ra_sel;
      r_ra_out    <= w_ra_out;
      r_condition <= w_condition;
      r_con_in    <= w_con_in;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ra   <= 4'h0;
      r_cond <= 2'b00;
      r_c    <= '0;
    end else if (w_accept) begin
      r_ra   <= seq.in_ir[RA_MSB:RA_LSB];
      r_cond <= seq.in_ir[COND_MSB:COND_LSB];
      r_c    <= seq.in_ir[C_LSB +: OFFSET_W];
    end
  end

  branch_target_adder #(
    .OFFSET_W (OFFSET_W)
  ) u_target_adder (
    .i_pc     (r_pc),
    .i_offset (r_c),
    .o_target (w_target)
  );

  // An increment accepted alongside start lands before EVAL, so the branch adds to pc+1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (seq.in_pc_inc) r_pc <= r_pc + 32'd1;
    end else if (r_state == ST_EVAL) begin
      r_taken <= seq.in_branch;
      if (seq.in_branch) r_pc <= w_target;
    end
  end

`ifdef BRANCH_CHECK_EN
  logic r_expect;
  logic r_mismatch;

  // Bus is stable during STROBE; the expected flag is held for comparison in EVAL.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_expect   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_state == ST_STROBE) r_expect <= cond_flag(r_cond, seq.in_bus);
      r_mismatch <= (r_state == ST_EVAL) && (r_expect != seq.in_branch);
    end
  end

  assign seq.out_mismatch = r_mismatch;
`endif

  assign seq.out_ra_sel    = r_ra_sel;
  assign seq.out_ra_out    = r_ra_out;
  assign seq.out_condition = r_condition;
  assign seq.out_con_in    = r_con_in;
  assign seq.out_pc        = r_pc;
  assign seq.out_busy      = r_busy;
  assign seq.out_done      = r_done;
  assign seq.out_taken     = r_taken;

endmodule
